// File: rtl/sc_pkg.sv
// Shared types and default sizing for the sequence counter slice.
package sc_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } sc_state_t;

  localparam int unsigned SC_N     = 4;
  localparam int unsigned SC_MAX_T = 15;

endpackage : sc_pkg

// File: rtl/sc_wdog.sv
// Watchdog for the sequence counter: counts RUN cycles since the last sequence
// boundary and flags expiry on the edge where the count reaches WDOG.
module sc_wdog #(
  parameter int unsigned WDOG = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic boundary_i,
  output logic expire_o
);

  localparam int unsigned W = $clog2(WDOG + 1);

  logic [W-1:0] cnt_q;

  assign expire_o = run_i && !boundary_i && (cnt_q == W'(WDOG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (run_i) begin
      if (boundary_i)        cnt_q <= '0;
      else if (!expire_o)    cnt_q <= cnt_q + W'(1);
    end
  end

endmodule : sc_wdog

// File: rtl/seq_counter.sv
// Sequence counter driving the timing decoder select lines, with halt-on-boundary
// and a saturating completed-sequence count. Optional watchdog: SC_WDOG_EN.
module seq_counter
  import sc_pkg::*;
#(
  parameter int unsigned N     = SC_N,
  parameter int unsigned MAX_T = SC_MAX_T,
  parameter int unsigned CW    = 8,
  parameter int unsigned WDOG  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sc_clr,
  input  logic          sc_ld,
  input  logic [N-1:0]  sc_ld_val,
  input  logic          sc_inc,
  input  logic          halt_req,
  input  logic          resume,
  output logic [N-1:0]  sc_out,
  output logic          sc_wrap,
  output logic [CW-1:0] seq_cnt,
  output logic          halted,
  output logic          wdog_fault
);

  localparam logic [N-1:0] MAX_V = N'(MAX_T);

  if (MAX_T < 1 || MAX_T > (2**N) - 1 || WDOG < 1) begin : g_bad_param
    $error("seq_counter: MAX_T or WDOG out of range");
  end

  sc_state_t     state_q;
  logic [N-1:0]  sc_q;
  logic          wrap_q;
  logic [CW-1:0] seq_cnt_q;
  logic          halted_q;

  logic          boundary_d;
  logic [N-1:0]  ld_val_d;
  logic [CW-1:0] seq_cnt_d;
  logic          expire_d;

  // A clear always ends a sequence; a wrap only counts if nothing outranks the increment.
  assign boundary_d = (state_q == RUN) &&
                      (sc_clr || (!sc_ld && sc_inc && (sc_q == MAX_V)));
  assign ld_val_d   = (sc_ld_val > MAX_V) ? MAX_V : sc_ld_val;
  assign seq_cnt_d  = (&seq_cnt_q) ? seq_cnt_q : seq_cnt_q + CW'(1);

`ifdef SC_WDOG_EN
  sc_wdog #(.WDOG(WDOG)) u_wdog (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_i      (state_q == RUN),
    .boundary_i (boundary_d),
    .expire_o   (expire_d)
  );
  assign wdog_fault = (state_q == FAULT);
`else
  assign expire_d   = 1'b0;
  assign wdog_fault = 1'b0;
`endif

  // NOTE: all state here is written with <= so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      sc_q      <= '0;
      wrap_q    <= 1'b0;
      seq_cnt_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      unique case (state_q)
        RUN: begin
          if (expire_d) begin
            state_q <= FAULT;
            sc_q    <= '0;
          end else begin
            if (sc_clr)                         sc_q <= '0;
            else if (sc_ld)                     sc_q <= ld_val_d;
            else if (sc_inc && sc_q == MAX_V) begin
              sc_q   <= '0;
              wrap_q <= 1'b1;
            end
            else if (sc_inc)                    sc_q <= sc_q + N'(1);

            if (boundary_d) begin
              seq_cnt_q <= seq_cnt_d;
              if (halt_req) begin
                state_q  <= HALTED;
                halted_q <= 1'b1;
              end
            end
          end
        end
        HALTED: begin
          sc_q <= '0;
          if (resume && !halt_req) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          // FAULT is terminal until reset.
          sc_q     <= '0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign sc_out  = sc_q;
  assign sc_wrap = wrap_q;
  assign seq_cnt = seq_cnt_q;
  assign halted  = halted_q;

endmodule : seq_counter

// File: tb/tb_seq_counter.sv
// Scoreboard bench for seq_counter: a default instance (MAX_T=15) and a MAX_T=11
// instance share stimulus; a behavioural model pushes expectations per edge.
module tb_seq_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sc_clr = 1'b0;
  logic       sc_ld = 1'b0;
  logic [3:0] sc_ld_val = 4'd0;
  logic       sc_inc = 1'b0;
  logic       halt_req = 1'b0;
  logic       resume = 1'b0;

  logic [3:0] sc_out0, sc_out1;
  logic       sc_wrap0, sc_wrap1;
  logic [7:0] seq_cnt0, seq_cnt1;
  logic       halted0, halted1;
  logic       wdog_fault0, wdog_fault1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_counter dut (
    .clk(clk), .rst_n(rst_n), .sc_clr(sc_clr), .sc_ld(sc_ld), .sc_ld_val(sc_ld_val),
    .sc_inc(sc_inc), .halt_req(halt_req), .resume(resume),
    .sc_out(sc_out0), .sc_wrap(sc_wrap0), .seq_cnt(seq_cnt0), .halted(halted0),
    .wdog_fault(wdog_fault0)
  );

  seq_counter #(.MAX_T(11)) dut11 (
    .clk(clk), .rst_n(rst_n), .sc_clr(sc_clr), .sc_ld(sc_ld), .sc_ld_val(sc_ld_val),
    .sc_inc(sc_inc), .halt_req(halt_req), .resume(resume),
    .sc_out(sc_out1), .sc_wrap(sc_wrap1), .seq_cnt(seq_cnt1), .halted(halted1),
    .wdog_fault(wdog_fault1)
  );

  typedef struct {
    int dut_idx;
    int sc;
    int wrap;
    int cnt;
    int halt;
    int fault;
  } exp_t;

  exp_t sb[$];

  int m_sc[2], m_wrap[2], m_cnt[2], m_halt[2], m_fault[2], m_wd[2];

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sc[i] = 0; m_wrap[i] = 0; m_cnt[i] = 0;
      m_halt[i] = 0; m_fault[i] = 0; m_wd[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int mx;
    bit bnd;
    mx = (i == 0) ? 15 : 11;
    m_wrap[i] = 0;
    if (m_fault[i] != 0) begin
      m_sc[i] = 0;
      return;
    end
    if (m_halt[i] != 0) begin
      if (resume && !halt_req) m_halt[i] = 0;
      return;
    end
    bnd = sc_clr || (!sc_ld && sc_inc && m_sc[i] == mx);
`ifdef SC_WDOG_EN
    if (!bnd && m_wd[i] == 31) begin
      m_fault[i] = 1;
      m_sc[i] = 0;
      return;
    end
    m_wd[i] = bnd ? 0 : m_wd[i] + 1;
`endif
    if (sc_clr) m_sc[i] = 0;
    else if (sc_ld) m_sc[i] = (int'(sc_ld_val) > mx) ? mx : int'(sc_ld_val);
    else if (sc_inc) begin
      if (m_sc[i] == mx) begin
        m_sc[i] = 0;
        m_wrap[i] = 1;
      end else begin
        m_sc[i] = m_sc[i] + 1;
      end
    end
    if (bnd) begin
      if (m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
      if (halt_req) m_halt[i] = 1;
    end
  endtask

  task automatic compare_out();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.dut_idx == 0) begin
        check("d15.sc_out",  int'(sc_out0),     e.sc);
        check("d15.sc_wrap", int'(sc_wrap0),    e.wrap);
        check("d15.seq_cnt", int'(seq_cnt0),    e.cnt);
        check("d15.halted",  int'(halted0),     e.halt);
        check("d15.wdog",    int'(wdog_fault0), e.fault);
      end else begin
        check("d11.sc_out",  int'(sc_out1),     e.sc);
        check("d11.sc_wrap", int'(sc_wrap1),    e.wrap);
        check("d11.seq_cnt", int'(seq_cnt1),    e.cnt);
        check("d11.halted",  int'(halted1),     e.halt);
        check("d11.wdog",    int'(wdog_fault1), e.fault);
      end
    end
  endtask

  task automatic push_expect();
    for (int i = 0; i < 2; i++)
      sb.push_back('{dut_idx: i, sc: m_sc[i], wrap: m_wrap[i], cnt: m_cnt[i],
                     halt: m_halt[i], fault: m_fault[i]});
  endtask

  // Drive one cycle of controls, predict, then compare just after the edge.
  task automatic step(input logic clr, input logic ld, input logic [3:0] val,
                      input logic inc, input logic hreq, input logic res);
    sc_clr = clr; sc_ld = ld; sc_ld_val = val; sc_inc = inc;
    halt_req = hreq; resume = res;
    model_step(0);
    model_step(1);
    push_expect();
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sc_clr = 0; sc_ld = 0; sc_ld_val = 0; sc_inc = 0; halt_req = 0; resume = 0;
    model_reset();
    #1;
    push_expect();
    compare_out();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset, then a run of increments wrapping both instances.
    do_reset();
    for (int k = 0; k < 24; k++) step(0, 0, 4'd0, 1, 0, 0);
    check("d11.no_12", int'(sc_out1 == 4'd12), 0);

    // Priority: clear beats load and increment; load clamps to MAX_T.
    do_reset();
    step(0, 1, 4'd5, 0, 0, 0);
    step(1, 1, 4'd9, 1, 0, 0);
    step(0, 1, 4'd15, 0, 0, 0);
    // Clear together with increment at MAX_T: clear wins, no wrap.
    step(1, 0, 4'd0, 1, 0, 0);

    // Halt request only takes effect at the wrap boundary.
    do_reset();
    step(0, 1, 4'd3, 0, 0, 0);
    for (int k = 0; k < 14; k++) step(0, 0, 4'd0, 1, 1, 0);
    for (int k = 0; k < 3; k++)  step(1, 1, 4'd7, 1, 0, 0);
    step(0, 0, 4'd0, 1, 1, 1);
    step(0, 0, 4'd0, 0, 0, 1);
    step(0, 0, 4'd0, 1, 0, 0);
    step(0, 0, 4'd0, 1, 0, 0);

    // Asynchronous reset mid-sequence, between clock edges.
    do_reset();
    step(0, 1, 4'd7, 0, 0, 0);
    step(0, 0, 4'd0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    push_expect();
    compare_out();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 4'd0, 1, 0, 0);

    // Watchdog: 32 cycles without a boundary; fault is sticky through clear.
    do_reset();
    step(0, 1, 4'd5, 0, 0, 0);
    for (int k = 0; k < 31; k++) step(0, 0, 4'd0, 0, 0, 0);
    step(1, 0, 4'd0, 0, 0, 0);
    step(0, 1, 4'd4, 1, 0, 0);
    do_reset();
    step(0, 0, 4'd0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_seq_counter
